// File: rtl/gcd_engine.sv
// gcd_engine: Euclidean GCD unit with its own control FSM and a bit-serial
// restoring modulo datapath. Operands are captured on start_i, the result is
// returned with a one-cycle done_o pulse. Both-zero operands raise err_o.
// Optional feature macro: GCD_ITER_CNT_EN adds iter_cnt_o, a saturating count
// of the modulo steps taken for the last operation.
module gcd_engine #(
    parameter int WIDTH  = 16,
    parameter int ITER_W = 8
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] gcd_o,
`ifdef GCD_ITER_CNT_EN
    output logic             err_o,
    output logic [ITER_W-1:0] iter_cnt_o
`else
    output logic             err_o
`endif
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SORT,
        S_MOD,
        S_CHECK,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_x;
    logic [WIDTH-1:0]   r_y;
    logic [WIDTH:0]     r_rem;
    logic [CNT_W-1:0]   r_bit;

    logic [WIDTH-1:0]   w_max;
    logic [WIDTH-1:0]   w_min;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_y_ext;
    logic [WIDTH:0]     w_rem_next;

`ifdef GCD_ITER_CNT_EN
    logic [ITER_W-1:0]  r_k;
    logic [ITER_W-1:0]  w_k_inc;

    // Step counter increment that sticks at all-ones instead of wrapping.
    always_comb begin
        w_k_inc = (&r_k) ? r_k : r_k + 1'b1;
    end
`else
    // ITER_W only sizes the optional counter; keep it referenced so the
    // default build stays warning-free.
    logic w_unused_iter;
    assign w_unused_iter = ITER_W[0];
`endif

    // Operand ordering and one restoring-division step (shift in next dividend
    // bit, subtract divisor when it fits; the quotient bit is not kept).
    always_comb begin
        w_max      = (r_x >= r_y) ? r_x : r_y;
        w_min      = (r_x >= r_y) ? r_y : r_x;
        w_y_ext    = {1'b0, r_y};
        w_shift    = {r_rem[WIDTH-1:0], r_x[r_bit]};
        w_rem_next = (w_shift >= w_y_ext) ? (w_shift - w_y_ext) : w_shift;
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_rem   <= '0;
            r_bit   <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            gcd_o   <= '0;
            err_o   <= 1'b0;
`ifdef GCD_ITER_CNT_EN
            r_k        <= '0;
            iter_cnt_o <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        r_x     <= a_i;
                        r_y     <= b_i;
                        gcd_o   <= '0;
                        err_o   <= 1'b0;
                        busy_o  <= 1'b1;
                        r_state <= S_SORT;
`ifdef GCD_ITER_CNT_EN
                        r_k     <= '0;
`endif
                    end
                end

                S_SORT: begin
                    r_x <= w_max;
                    r_y <= w_min;
                    if (w_min == '0) begin
                        // Any zero operand: the other one is the answer, no steps.
                        gcd_o   <= w_max;
                        err_o   <= (w_max == '0);
                        done_o  <= 1'b1;
                        r_state <= S_DONE;
`ifdef GCD_ITER_CNT_EN
                        iter_cnt_o <= r_k;
`endif
                    end else begin
                        r_rem   <= '0;
                        r_bit   <= CNT_W'(WIDTH - 1);
                        r_state <= S_MOD;
                    end
                end

                S_MOD: begin
                    r_rem <= w_rem_next;
                    if (r_bit == '0) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_bit <= r_bit - 1'b1;
                    end
                end

                S_CHECK: begin
`ifdef GCD_ITER_CNT_EN
                    r_k <= w_k_inc;
`endif
                    if (r_rem == '0) begin
                        gcd_o   <= r_y;
                        err_o   <= 1'b0;
                        done_o  <= 1'b1;
                        r_state <= S_DONE;
`ifdef GCD_ITER_CNT_EN
                        iter_cnt_o <= w_k_inc;
`endif
                    end else begin
                        // Euclid step: (x, y) <- (y, x mod y).
                        r_x     <= r_y;
                        r_y     <= r_rem[WIDTH-1:0];
                        r_rem   <= '0;
                        r_bit   <= CNT_W'(WIDTH - 1);
                        r_state <= S_MOD;
                    end
                end

                S_DONE: begin
                    // start_i is deliberately not looked at here.
                    done_o  <= 1'b0;
                    busy_o  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    done_o  <= 1'b0;
                    busy_o  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
